// File: rtl/recipe_sequencer.sv
// Beverage-dispense sequencer: walks the masked ingredient steps in index order.
// Each step closes on a timer or on the level comparator (with an optional timeout).
module recipe_sequencer #(
  parameter int N_STEPS = 5,
  parameter int TIME_W  = 8
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_start,
  input  logic                            i_abort,
  input  logic                            i_ack,
  input  logic [N_STEPS-1:0]              i_recipe_mask,
  input  logic [N_STEPS-1:0]              i_step_mode,
  input  logic [N_STEPS*TIME_W-1:0]       i_step_time,
  input  logic                            i_level_ok,
  output logic [N_STEPS-1:0]              o_valve,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_fault,
  output logic [$clog2(N_STEPS+1)-1:0]    o_step_index,
  output logic [2:0]                      o_state_code
);

  localparam int IDX_W = $clog2(N_STEPS+1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEEK  = 3'd1,
    S_DISP  = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_index;
  logic [TIME_W-1:0]  r_timer;
  logic [N_STEPS-1:0] r_mask;
  logic [N_STEPS-1:0] r_mode;
  logic [TIME_W-1:0]  r_time [N_STEPS];

  logic               w_found;
  logic [IDX_W-1:0]   w_next;

  // Lowest enabled step at or above the current index.
  always_comb begin
    w_found = 1'b0;
    w_next  = '0;
    for (int unsigned i = 0; i < N_STEPS; i++) begin
      if (!w_found && r_mask[i] && (i >= 32'(r_index))) begin
        w_found = 1'b1;
        w_next  = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_index <= '0;
      r_timer <= '0;
      r_mask  <= '0;
      r_mode  <= '0;
      for (int unsigned i = 0; i < N_STEPS; i++) r_time[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            r_mask  <= i_recipe_mask;
            r_mode  <= i_step_mode;
            for (int unsigned i = 0; i < N_STEPS; i++)
              r_time[i] <= i_step_time[i*TIME_W +: TIME_W];
            r_index <= '0;
            r_state <= S_SEEK;
          end
        end
        S_SEEK: begin
          if (i_abort) begin
            r_state <= S_IDLE;
            r_index <= '0;
            r_timer <= '0;
          end else if (w_found) begin
            r_index <= w_next;
            r_timer <= r_time[w_next];
            r_state <= S_DISP;
          end else begin
            r_index <= IDX_W'(N_STEPS);
            r_state <= S_DONE;
          end
        end
        S_DISP: begin
          if (i_abort) begin
            r_state <= S_IDLE;
            r_index <= '0;
            r_timer <= '0;
          end else if (r_mode[r_index]) begin
            // Sensor step: level wins over a same-cycle timeout; timer==0 means no timeout.
            if (i_level_ok) begin
              r_index <= r_index + IDX_W'(1);
              r_state <= S_SEEK;
            end else if (r_timer == TIME_W'(1)) begin
              r_timer <= '0;
              r_state <= S_FAULT;
            end else if (r_timer != '0) begin
              r_timer <= r_timer - TIME_W'(1);
            end
          end else begin
            if (r_timer <= TIME_W'(1)) begin
              r_timer <= '0;
              r_index <= r_index + IDX_W'(1);
              r_state <= S_SEEK;
            end else begin
              r_timer <= r_timer - TIME_W'(1);
            end
          end
        end
        S_DONE, S_FAULT: begin
          if (i_abort || i_ack) begin
            r_state <= S_IDLE;
            r_index <= '0;
            r_timer <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_index <= '0;
          r_timer <= '0;
        end
      endcase
    end
  end

  always_comb begin
    o_valve = '0;
    for (int unsigned i = 0; i < N_STEPS; i++)
      o_valve[i] = (r_state == S_DISP) && (32'(r_index) == i);
    o_busy       = (r_state == S_SEEK) || (r_state == S_DISP);
    o_done       = (r_state == S_DONE);
    o_fault      = (r_state == S_FAULT);
    o_step_index = r_index;
    o_state_code = r_state;
  end

endmodule
